// File: rtl/ddr_mem_responder.sv
// Memory-side responder: DEPTH-word storage, one command at a time, fixed
// programmable read/write latency, registered ready/error/data and op counters.
module ddr_mem_responder #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 256,
    parameter int ADDR_LSB   = 4,
    parameter int RD_LATENCY = 4,
    parameter int WR_LATENCY = 2
) (
    input  logic              clk_ddr_400mhz,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_addr_bus,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic              mem_write_enable,
    input  logic              mem_read_enable,
    output logic [DATA_W-1:0] mem_read_data,
    output logic              mem_ready,
    output logic              resp_error,
    output logic [15:0]       resp_wr_count,
    output logic [15:0]       resp_rd_count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_wr_q, is_wr_d;
    logic              err_q, err_d;
    logic              oor_q, oor_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [DATA_W-1:0] rdata_q;
    logic              ready_q, error_q;
    logic [15:0]       wr_cnt_q, rd_cnt_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic addr_oor;
    assign addr_oor = (mem_addr_bus >> (ADDR_LSB + IDX_W)) != '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        err_d   = err_q;
        oor_d   = oor_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mem_write_enable || mem_read_enable) begin
                    // A write wins when both enables are high; the clash is flagged as an error.
                    is_wr_d = mem_write_enable;
                    err_d   = (mem_write_enable && mem_read_enable) || addr_oor;
                    oor_d   = addr_oor;
                    idx_d   = mem_addr_bus[ADDR_LSB +: IDX_W];
                    wdata_d = mem_write_data;
                    if (mem_write_enable) begin
                        cnt_d   = CNT_W'(WR_LATENCY - 1);
                        state_d = (WR_LATENCY == 1) ? RESP : BUSY;
                    end else begin
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                        state_d = (RD_LATENCY == 1) ? RESP : BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_ddr_400mhz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            err_q    <= 1'b0;
            oor_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
            oor_q   <= oor_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ready_q <= (state_q == RESP);
            error_q <= (state_q == RESP) && err_q;
            if (state_q == RESP) begin
                if (is_wr_q) begin
                    if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
                end else begin
                    if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
                    rdata_q <= oor_q ? '0 : mem_q[idx_q];
                end
            end
        end
    end

    // Storage is deliberately not reset; the write commits on the RESP edge.
    always_ff @(posedge clk_ddr_400mhz) begin
        if (!reset && state_q == RESP && is_wr_q && !oor_q)
            mem_q[idx_q] <= wdata_q;
    end

    assign mem_read_data = rdata_q;
    assign mem_ready     = ready_q;
    assign resp_error    = error_q;
    assign resp_wr_count = wr_cnt_q;
    assign resp_rd_count = rd_cnt_q;
endmodule
